systolic_pe: RTL and testbench

Parametrised output-stationary multiply-accumulate element for the matrix-multiplier systolic array. Each accepted beat multiplies `a_in` by `b_in`, accumulates over a programmable dot-product length, and forwards the operands one cycle later to the east and south neighbours. Completed dot products are held in a one-entry result register and drained through a valid/ready handshake, with backpressure to the operand stream.

---
 rtl/pe_pkg.sv | 41 ++++
 rtl/pe_mac_unit.sv | 85 ++++++++
 rtl/systolic_pe.sv | 183 ++++++++++++++++++
 tb/tb_systolic_pe.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the systolic_pe processing element:
//   - pe_state_e   : two-state accumulation FSM encoding (IDLE, ACC)
//   - K_MAX_DEFAULT / KLEN_W : default dot-product length limit and the
//                    matching width of the k_len port ($clog2(K_MAX)+1)
//   - EXT_MAX_W    : widest product/accumulator the extension helper handles
//   - ext_product  : sign- or zero-extends a raw product to EXT_MAX_W bits
// -----------------------------------------------------------------------------
package pe_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } pe_state_e;

    localparam int unsigned K_MAX_DEFAULT = 32'd256;
    localparam int unsigned KLEN_W        = $clog2(K_MAX_DEFAULT) + 32'd1;
    localparam int unsigned EXT_MAX_W     = 32'd128;

    // The caller places the prod_w-bit product in the LSBs with zeros above.
    // When is_signed is set the product MSB is replicated into every upper bit.
    function automatic logic [EXT_MAX_W-1:0] ext_product(
        input logic [EXT_MAX_W-1:0] prod,
        input int unsigned          prod_w,
        input logic                 is_signed
    );
        logic [EXT_MAX_W-1:0] msb_mask;
        logic [EXT_MAX_W-1:0] upper_mask;
        logic                 fill;
        msb_mask   = {{(EXT_MAX_W-1){1'b0}}, 1'b1} << (prod_w - 32'd1);
        upper_mask = {EXT_MAX_W{1'b1}} << prod_w;
        fill       = is_signed && ((prod & msb_mask) != {EXT_MAX_W{1'b0}});
        if (fill) begin
            ext_product = prod | upper_mask;
        end else begin
            ext_product = prod;
        end
    endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// -----------------------------------------------------------------------------
// pe_mac_unit
// Combinational multiply / extend / accumulate stage of the systolic PE.
//   a, b      : operands (DATA_W)
//   acc_in    : running accumulator (zero on the first beat of a dot product)
//   acc_next  : acc_in + extended product (wrapping, or clamped with PE_SAT_EN)
//   sat_hit   : this addition was clamped (always 0 unless PE_SAT_EN)
// Optional build macro: PE_SAT_EN selects saturating accumulation.
// -----------------------------------------------------------------------------
module pe_mac_unit
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  acc_next,
    output logic              sat_hit
);

    localparam int  PROD_W    = 2 * DATA_W;
    localparam logic IS_SIGNED = (SIGNED != 32'sd0);

    logic [PROD_W-1:0] a_x_s;
    logic [PROD_W-1:0] b_x_s;
    logic [PROD_W-1:0] prod_s;
    logic [ACC_W-1:0]  ext_s;

    // Widen operands to the product width, then multiply. The low PROD_W bits
    // of the product are identical for signed and unsigned interpretations
    // once the operands are extended the right way.
    always_comb begin
        if (IS_SIGNED) begin
            a_x_s = {{DATA_W{a[DATA_W-1]}}, a};
            b_x_s = {{DATA_W{b[DATA_W-1]}}, b};
        end else begin
            a_x_s = {{DATA_W{1'b0}}, a};
            b_x_s = {{DATA_W{1'b0}}, b};
        end
        prod_s = a_x_s * b_x_s;
        ext_s  = ACC_W'(ext_product(EXT_MAX_W'(prod_s), PROD_W, IS_SIGNED));
    end

`ifdef PE_SAT_EN
    logic [ACC_W:0] sum_w_s;

    // Add with one guard bit and clamp to the representable range on overflow.
    always_comb begin
        sum_w_s  = {(ACC_W+1){1'b0}};
        acc_next = {ACC_W{1'b0}};
        sat_hit  = 1'b0;
        if (IS_SIGNED) begin
            sum_w_s = {acc_in[ACC_W-1], acc_in} + {ext_s[ACC_W-1], ext_s};
            if (sum_w_s[ACC_W] != sum_w_s[ACC_W-1]) begin
                sat_hit = 1'b1;
                if (sum_w_s[ACC_W]) begin
                    acc_next = {1'b1, {(ACC_W-1){1'b0}}};
                end else begin
                    acc_next = {1'b0, {(ACC_W-1){1'b1}}};
                end
            end else begin
                acc_next = sum_w_s[ACC_W-1:0];
            end
        end else begin
            sum_w_s = {1'b0, acc_in} + {1'b0, ext_s};
            if (sum_w_s[ACC_W]) begin
                sat_hit  = 1'b1;
                acc_next = {ACC_W{1'b1}};
            end else begin
                acc_next = sum_w_s[ACC_W-1:0];
            end
        end
    end
`else
    // Plain modulo-2^ACC_W accumulation.
    always_comb begin
        acc_next = acc_in + ext_s;
        sat_hit  = 1'b0;
    end
`endif

endmodule

// File: rtl/systolic_pe.sv
// -----------------------------------------------------------------------------
// systolic_pe
// Output-stationary multiply-accumulate element for a systolic array.
// Each accepted operand beat is multiplied and accumulated over a dot product
// of k_len beats (0 treated as 1). Operands are forwarded east/south one cycle
// later. Completed dot products sit in a one-entry result register drained by
// a valid/ready handshake; a final beat stalls while that register is full.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   k_len               : dot-product length, sampled on the first beat
//   in_valid / in_ready : operand beat handshake
//   a_in, b_in          : row / column operands
//   a_out, b_out        : registered operand forward
//   fwd_valid           : registered accepted-beat strobe
//   res_valid/res_ready : result handshake, res_data the dot product
//   sat_flag            : sticky saturation indicator
// Optional build macro: PE_SAT_EN (saturating accumulation, live sat_flag).
// -----------------------------------------------------------------------------
module systolic_pe
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K_MAX  = K_MAX_DEFAULT,
    parameter int SIGNED = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [$clog2(K_MAX):0] k_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      a_in,
    input  logic [DATA_W-1:0]      b_in,
    output logic [DATA_W-1:0]      a_out,
    output logic [DATA_W-1:0]      b_out,
    output logic                   fwd_valid,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACC_W-1:0]       res_data,
    output logic                   sat_flag
);

    localparam int             KW    = $clog2(K_MAX) + 1;
    localparam logic [KW-1:0]  ONE_K = {{(KW-1){1'b0}}, 1'b1};

    pe_state_e         state_r;
    logic [ACC_W-1:0]  acc_r;
    logic [KW-1:0]     cnt_r;
    logic [KW-1:0]     len_r;
    logic [DATA_W-1:0] a_out_r;
    logic [DATA_W-1:0] b_out_r;
    logic              fwd_valid_r;
    logic              res_valid_r;
    logic [ACC_W-1:0]  res_data_r;
    logic              sat_flag_r;

    logic [KW-1:0]     klen_eff_s;
    logic [KW-1:0]     cnt_inc_s;
    logic              final_s;
    logic              in_ready_s;
    logic              accept_s;
    logic [ACC_W-1:0]  acc_base_s;
    logic [ACC_W-1:0]  acc_next_s;
    logic              sat_hit_s;

    // Decide whether the next beat would close the dot product and whether it
    // may be accepted. Only a final beat needs the result register to be free.
    always_comb begin
        if (k_len == {KW{1'b0}}) begin
            klen_eff_s = ONE_K;
        end else begin
            klen_eff_s = k_len;
        end
        cnt_inc_s = cnt_r + ONE_K;
        case (state_r)
            IDLE:    final_s = (klen_eff_s == ONE_K);
            ACC:     final_s = (cnt_inc_s == len_r);
            default: final_s = 1'b0;
        endcase
        in_ready_s = !(final_s && res_valid_r && !res_ready);
        accept_s   = in_valid && in_ready_s;
        if (state_r == ACC) begin
            acc_base_s = acc_r;
        end else begin
            acc_base_s = {ACC_W{1'b0}};
        end
    end

    pe_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .a        (a_in),
        .b        (b_in),
        .acc_in   (acc_base_s),
        .acc_next (acc_next_s),
        .sat_hit  (sat_hit_s)
    );

    // Accumulation FSM: IDLE waits for the first beat, ACC counts the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {KW{1'b0}};
            len_r   <= {KW{1'b0}};
        end else if (accept_s) begin
            if (final_s) begin
                state_r <= IDLE;
                acc_r   <= {ACC_W{1'b0}};
                cnt_r   <= {KW{1'b0}};
                if (state_r == IDLE) begin
                    len_r <= klen_eff_s;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        len_r   <= klen_eff_s;
                        cnt_r   <= ONE_K;
                        acc_r   <= acc_next_s;
                        state_r <= ACC;
                    end
                    ACC: begin
                        cnt_r <= cnt_inc_s;
                        acc_r <= acc_next_s;
                    end
                    default: begin
                        state_r <= IDLE;
                        acc_r   <= {ACC_W{1'b0}};
                        cnt_r   <= {KW{1'b0}};
                    end
                endcase
            end
        end
    end

    // One-entry result register; a final beat landing during a drain reloads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            res_data_r  <= {ACC_W{1'b0}};
        end else if (accept_s && final_s) begin
            res_valid_r <= 1'b1;
            res_data_r  <= acc_next_s;
        end else if (res_ready) begin
            res_valid_r <= 1'b0;
        end
    end

    // Operand forward to the east/south neighbours on accepted beats only.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out_r     <= {DATA_W{1'b0}};
            b_out_r     <= {DATA_W{1'b0}};
            fwd_valid_r <= 1'b0;
        end else begin
            fwd_valid_r <= accept_s;
            if (accept_s) begin
                a_out_r <= a_in;
                b_out_r <= b_in;
            end
        end
    end

    // Sticky clamp indicator; sat_hit_s is constant 0 in the wrapping build.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag_r <= 1'b0;
        end else if (accept_s && sat_hit_s) begin
            sat_flag_r <= 1'b1;
        end
    end

    assign in_ready  = in_ready_s;
    assign a_out     = a_out_r;
    assign b_out     = b_out_r;
    assign fwd_valid = fwd_valid_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign sat_flag  = sat_flag_r;

endmodule

// File: tb/tb_systolic_pe.sv
// -----------------------------------------------------------------------------
// tb_systolic_pe
// Two PEs share one stimulus stream: a signed 32-bit accumulator build and an
// unsigned 16-bit accumulator build. A bench model computes each expected dot
// product when its final beat is accepted and pushes it to a per-DUT queue; a
// monitor pops and compares on every result handshake.
// -----------------------------------------------------------------------------
module tb_systolic_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  k_len;
    logic        in_valid;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        res_ready;

    logic        m_in_ready, m_fwd_valid, m_res_valid, m_sat_flag;
    logic [7:0]  m_a_out, m_b_out;
    logic [31:0] m_res_data;
    logic        u_in_ready, u_fwd_valid, u_res_valid, u_sat_flag;
    logic [7:0]  u_a_out, u_b_out;
    logic [15:0] u_res_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_q[$];
    logic [15:0] u_q[$];
    logic [31:0] mdl_m_acc;
    logic [15:0] mdl_u_acc;
    int          mdl_cnt;
    int          mdl_len;
    logic        exp_u_sat;
    logic        exp_m_sat;

    always #5 clk = ~clk;

    systolic_pe #(.DATA_W(8), .ACC_W(32), .K_MAX(256), .SIGNED(1)) dut_m (
        .clk(clk), .rst(rst), .k_len(k_len), .in_valid(in_valid),
        .in_ready(m_in_ready), .a_in(a_in), .b_in(b_in),
        .a_out(m_a_out), .b_out(m_b_out), .fwd_valid(m_fwd_valid),
        .res_valid(m_res_valid), .res_ready(res_ready),
        .res_data(m_res_data), .sat_flag(m_sat_flag)
    );

    systolic_pe #(.DATA_W(8), .ACC_W(16), .K_MAX(256), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .k_len(k_len), .in_valid(in_valid),
        .in_ready(u_in_ready), .a_in(a_in), .b_in(b_in),
        .a_out(u_a_out), .b_out(u_b_out), .fwd_valid(u_fwd_valid),
        .res_valid(u_res_valid), .res_ready(res_ready),
        .res_data(u_res_data), .sat_flag(u_sat_flag)
    );

    // Scoreboard: every result handshake must match the oldest expected value.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_res_valid && res_ready) begin
                checks++;
                if (m_q.size() == 0) begin
                    failures++;
                    $display("FAIL m_unexpected_result: got %h expected none", m_res_data);
                end else begin
                    logic [31:0] e;
                    e = m_q.pop_front();
                    if (m_res_data !== e) begin
                        failures++;
                        $display("FAIL m_res_data: got %h expected %h", m_res_data, e);
                    end
                end
            end
            if (u_res_valid && res_ready) begin
                checks++;
                if (u_q.size() == 0) begin
                    failures++;
                    $display("FAIL u_unexpected_result: got %h expected none", u_res_data);
                end else begin
                    logic [15:0] e;
                    e = u_q.pop_front();
                    if (u_res_data !== e) begin
                        failures++;
                        $display("FAIL u_res_data: got %h expected %h", u_res_data, e);
                    end
                end
            end
        end
    end

    task automatic model_clear();
        mdl_cnt   = 0;
        mdl_m_acc = 32'd0;
        mdl_u_acc = 16'd0;
        exp_u_sat = 1'b0;
        exp_m_sat = 1'b0;
    endtask

    // Reference behaviour for one accepted beat on both DUT flavours.
    task automatic model_beat(input logic [7:0] a, input logic [7:0] b, input logic [8:0] k);
        longint ps, pu, ss, su;
        if (mdl_cnt == 0) begin
            mdl_len   = (k == 9'd0) ? 1 : int'(k);
            mdl_m_acc = 32'd0;
            mdl_u_acc = 16'd0;
        end
        ps = longint'($signed(a)) * longint'($signed(b));
        pu = longint'(a) * longint'(b);
        ss = longint'($signed(mdl_m_acc)) + ps;
        su = longint'(mdl_u_acc) + pu;
`ifdef PE_SAT_EN
        if (ss > 64'sd2147483647) begin
            ss = 64'sd2147483647;
            exp_m_sat = 1'b1;
        end
        if (ss < -64'sd2147483648) begin
            ss = -64'sd2147483648;
            exp_m_sat = 1'b1;
        end
        if (su > 64'sd65535) begin
            su = 64'sd65535;
            exp_u_sat = 1'b1;
        end
`endif
        mdl_m_acc = ss[31:0];
        mdl_u_acc = su[15:0];
        mdl_cnt++;
        if (mdl_cnt == mdl_len) begin
            m_q.push_back(mdl_m_acc);
            u_q.push_back(mdl_u_acc);
            mdl_cnt = 0;
        end
    endtask

    // Offer one beat (called just after a rising edge); returns just after the
    // edge that accepts it. stalls reports how many cycles in_ready was low.
    task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                             input logic [8:0] k, output int stalls);
        a_in     = a;
        b_in     = b;
        k_len    = k;
        in_valid = 1'b1;
        stalls   = 0;
        @(negedge clk);
        while (!m_in_ready && stalls < 20) begin
            @(negedge clk);
            stalls++;
        end
        if (!m_in_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got in_ready=0 expected 1 within 20 cycles");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model_beat(a, b, k);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        a_in      = 8'd5;
        b_in      = 8'd7;
        k_len     = 9'd1;
        res_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_a_out, m_b_out, m_fwd_valid, m_res_valid, m_sat_flag} !== 19'd0) begin
            failures++;
            $display("FAIL reset_m_ctrl: got %h expected 0", {m_a_out, m_b_out, m_fwd_valid, m_res_valid, m_sat_flag});
        end
        checks++;
        if (m_res_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_m_res_data: got %h expected 0", m_res_data);
        end
        checks++;
        if ({u_a_out, u_b_out, u_fwd_valid, u_res_valid, u_sat_flag, u_res_data} !== 35'd0) begin
            failures++;
            $display("FAIL reset_u_outputs: got %h expected 0", {u_a_out, u_b_out, u_fwd_valid, u_res_valid, u_sat_flag, u_res_data});
        end
        checks++;
        if ({m_in_ready, u_in_ready} !== 2'b11) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 11", {m_in_ready, u_in_ready});
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({m_res_valid, u_res_valid, m_fwd_valid} !== 3'b000) begin
                failures++;
                $display("FAIL reset_no_result: got %b expected 000", {m_res_valid, u_res_valid, m_fwd_valid});
            end
        end
    endtask

    task automatic test_unsigned_dot();
        logic [7:0] av [4];
        logic [7:0] bv [4];
        int st;
        av = '{8'd1, 8'd3, 8'd5, 8'd7};
        bv = '{8'd2, 8'd4, 8'd6, 8'd8};
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_beat(av[i], bv[i], 9'd4, st);
            checks++;
            if ({u_a_out, u_b_out, u_fwd_valid} !== {av[i], bv[i], 1'b1}) begin
                failures++;
                $display("FAIL fwd_beat%0d: got %h expected %h", i, {u_a_out, u_b_out, u_fwd_valid}, {av[i], bv[i], 1'b1});
            end
            checks++;
            if (u_res_valid !== (i == 3)) begin
                failures++;
                $display("FAIL dot4_res_valid_beat%0d: got %b expected %b", i, u_res_valid, (i == 3));
            end
        end
        checks++;
        if (u_res_data !== 16'd100 || m_res_data !== 32'd100) begin
            failures++;
            $display("FAIL dot4_value: got %h/%h expected 100", u_res_data, m_res_data);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({u_res_valid, u_fwd_valid, u_a_out} !== {1'b0, 1'b0, 8'd7}) begin
            failures++;
            $display("FAIL dot4_after: got %h expected %h", {u_res_valid, u_fwd_valid, u_a_out}, {1'b0, 1'b0, 8'd7});
        end
    endtask

    task automatic test_signed_dot();
        int st;
        res_ready = 1'b1;
        send_beat(8'hFF, 8'h02, 9'd2, st);
        send_beat(8'h80, 8'h7F, 9'd2, st);
        in_valid = 1'b0;
        checks++;
        if (m_res_data !== 32'hFFFFC07E) begin
            failures++;
            $display("FAIL signed_dot: got %h expected FFFFC07E", m_res_data);
        end
        checks++;
        if (u_res_data !== 16'h417E) begin
            failures++;
            $display("FAIL unsigned_view: got %h expected 417E", u_res_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int st;
        res_ready = 1'b0;
        send_beat(8'd2, 8'd3, 9'd1, st);
        a_in  = 8'd4;
        b_in  = 8'd5;
        k_len = 9'd1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({m_in_ready, m_res_valid, m_res_data} !== {1'b0, 1'b1, 32'd6}) begin
                failures++;
                $display("FAIL bp_hold: got %h expected %h", {m_in_ready, m_res_valid, m_res_data}, {1'b0, 1'b1, 32'd6});
            end
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got in_ready=%b expected 1", m_in_ready);
        end
        @(posedge clk);
        #1;
        model_beat(8'd4, 8'd5, 9'd1);
        in_valid  = 1'b0;
        res_ready = 1'b0;
        checks++;
        if ({m_res_valid, m_res_data, u_res_data} !== {1'b1, 32'd20, 16'd20}) begin
            failures++;
            $display("FAIL bp_reload: got %h expected %h", {m_res_valid, m_res_data, u_res_data}, {1'b1, 32'd20, 16'd20});
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m_res_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: got res_valid=%b expected 0", m_res_valid);
        end
    endtask

    task automatic test_saturation();
        int st;
        res_ready = 1'b1;
        send_beat(8'd255, 8'd255, 9'd2, st);
        send_beat(8'd255, 8'd255, 9'd2, st);
        in_valid = 1'b0;
`ifdef PE_SAT_EN
        checks++;
        if ({u_res_data, u_sat_flag} !== {16'hFFFF, 1'b1}) begin
            failures++;
            $display("FAIL sat_u: got %h expected %h", {u_res_data, u_sat_flag}, {16'hFFFF, 1'b1});
        end
`else
        checks++;
        if ({u_res_data, u_sat_flag} !== {16'hFC02, 1'b0}) begin
            failures++;
            $display("FAIL wrap_u: got %h expected %h", {u_res_data, u_sat_flag}, {16'hFC02, 1'b0});
        end
`endif
        checks++;
        if ({m_res_data, m_sat_flag} !== {32'd2, 1'b0}) begin
            failures++;
            $display("FAIL sat_m: got %h expected %h", {m_res_data, m_sat_flag}, {32'd2, 1'b0});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        int st;
        res_ready = 1'b1;
        send_beat(8'd9, 8'd9, 9'd4, st);
        send_beat(8'd9, 8'd9, 9'd4, st);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        checks++;
        if ({u_sat_flag, m_sat_flag, u_res_valid} !== 3'b000) begin
            failures++;
            $display("FAIL midop_reset_state: got %b expected 000", {u_sat_flag, m_sat_flag, u_res_valid});
        end
        send_beat(8'd3, 8'd3, 9'd1, st);
        in_valid = 1'b0;
        checks++;
        if ({m_res_valid, m_res_data} !== {1'b1, 32'd9}) begin
            failures++;
            $display("FAIL midop_fresh: got %h expected %h", {m_res_valid, m_res_data}, {1'b1, 32'd9});
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (m_res_valid !== 1'b0) begin
                failures++;
                $display("FAIL midop_stale: got res_valid=%b expected 0", m_res_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int st;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 9'd2, st);
            checks++;
            if (st != 0) begin
                failures++;
                $display("FAIL b2b_bubble%0d: got %0d stalls expected 0", i, st);
            end
            checks++;
            if (m_res_valid !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL b2b_res_valid%0d: got %b expected %b", i, m_res_valid, (i % 2 == 1));
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({u_sat_flag, m_sat_flag} !== {exp_u_sat, exp_m_sat}) begin
            failures++;
            $display("FAIL b2b_sat_flag: got %b expected %b", {u_sat_flag, m_sat_flag}, {exp_u_sat, exp_m_sat});
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_dot();
        test_signed_dot();
        test_backpressure();
        test_saturation();
        test_reset_midop();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_q.size() != 0 || u_q.size() != 0) begin
            failures++;
            $display("FAIL missing_results: got %0d/%0d pending expected 0", m_q.size(), u_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
